rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (WE3/A3/WD3) between two requesters: the pipeline writeback stage and late load returns from the data cache after a miss.
- Buffers load returns in a small FIFO and applies a starvation-bounded priority scheme.
- Keeps a 32-entry pending-load scoreboard, which drives hazard stalls to decode and blocks a second outstanding load to the same register.

Parameters:
- FIFO_DEPTH, 2, load-return buffer entries (power of 2, ≥2).
- STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO may go undrained before load return takes priority.
- DATA_WIDTH, 32, register data width.
- ADDR_WIDTH, 5, register index width.

Ports:
- clk  in  1  system clock, rising edge.
- RST  in  1  reset; synchronous, active-low.
- wb_valid  in  1  pipeline writeback request.
- wb_addr  in  5  writeback destination register.
- wb_data  in  32  writeback data.
- wb_hold  out  1  writeback not accepted this cycle; pipeline holds WB and stalls.
- ld_issue  in  1  load leaving execute toward the cache.
- ld_issue_addr  in  5  load destination register.
- ld_issue_stall  out  1  issue refused: destination already pending.
- ld_ret_valid  in  1  cache load data valid.
- ld_ret_addr  in  5  returning load destination register.
- ld_ret_data  in  32  returning load data.
- ld_ret_ready  out  1  FIFO can accept a return.
- rs1_addr, rs2_addr, rd_addr  in  5 each  decode-stage register indices.
- hazard_stall  out  1  decode must stall.
- WE3  out  1  register-file write enable.
- A3  out  5  register-file write address.
- WD3  out  32  register-file write data.

Behaviour:
- Reset (RST low at a clk edge): FIFO flushed, count=0, pending vector=0, starve_cnt=0.
- While RST is low, all outputs are forced to 0; this holds even mid-operation and mid-drain.
- FIFO push: ld_ret_valid && ld_ret_ready.
  - ld_ret_addr==0 is accepted and discarded, never enqueued.
  - ld_ret_ready = (count != FIFO_DEPTH), computed from registered count.
  - Push and pop in the same cycle are legal at any count.
- No bypass: a returning load is written to the register file no earlier than the cycle after acceptance.
- Grant, evaluated combinationally each cycle:
  - load_pri = fifo_nonempty && (starve_cnt == STARVE_LIMIT).
  - If load_pri: drain the FIFO head; wb_hold = wb_valid.
  - Else if wb_valid: write wb_addr/wb_data; wb_hold=0; the FIFO waits.
  - Else if fifo_nonempty: drain the FIFO head.
  - Else: idle.
- Write port:
  - A3/WD3 come from the granted source; they are 0 when idle.
  - WE3 = granted && (A3 != 0). A write to x0 is never presented.
- starve_cnt:
  - Cleared on any drain or when the FIFO is empty.
  - Otherwise +1 per cycle, saturating at STARVE_LIMIT.
- Scoreboard pending[31:0], pending[0] hard-wired to 0:
  - Set on an accepted issue: ld_issue && !ld_issue_stall && ld_issue_addr != 0.
  - Cleared when the FIFO head is drained to the register file.
  - If set and clear target the same register in the same cycle, set wins.
- ld_issue_stall = ld_issue && addr != 0 && pending[addr] && !(drain && head_addr == addr).
- hazard_stall:
  - Asserted if pending[rs1_addr], pending[rs2_addr] or pending[rd_addr] is set. The rd term covers WAW ordering against the in-flight load.
  - Uses registered pending only, so it is conservative in the drain cycle and released one cycle later.
- A load return to a non-pending register is written normally and does not affect the scoreboard.
- Wrap-around: FIFO pointers are ADDR-sized modulo FIFO_DEPTH; count is width clog2(FIFO_DEPTH)+1.

Decomposition:
- Shared package rf_pkg:
  - REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32.
  - Grant-source encoding: GNT_NONE, GNT_WB, GNT_LD.
- One sub-module rf_ld_fifo:
  - Synchronous FIFO with push/pop/full/empty/head outputs and synchronous active-low reset.
  - The arbiter and scoreboard live in the top module.

Test Plan:
- Writeback alone: wb_valid=1, wb_addr=5, wb_data=0xDEADBEEF -> same cycle WE3=1, A3=5, WD3=0xDEADBEEF, wb_hold=0.
- Load round trip:
  - ld_issue to x7 -> next cycle pending[7]=1 and hazard_stall=1 for rs1_addr=7.
  - Return 0x1234 -> one cycle later WE3=1, A3=7, WD3=0x1234.
  - hazard_stall drops the cycle after that.
- Starvation:
  - Return to x3 while wb_valid is held high continuously -> FIFO waits 4 cycles.
  - Cycle 5: WE3 writes x3 and wb_hold=1 for exactly one cycle; writeback is granted the next cycle.
- FIFO full:
  - Two returns (x1, x2) under continuous writeback -> ld_ret_ready=0.
  - A third return is not accepted until the first drain.
- Duplicate issue / x0:
  - ld_issue to x9 while x9 is pending -> ld_issue_stall=1.
  - Issue in the drain cycle of x9 -> accepted, and pending[9] stays 1.
  - Return to x0 -> never enqueued, WE3 stays 0.
- Reset mid-operation: FIFO holding 2 entries, pending 0x000000C0, RST=0 for one edge -> count=0, pending=0, WE3=0, ld_ret_ready=1 after release.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write-port arbiter slice:
// register-file geometry and the grant-source encoding.
package rf_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  // Which requester owns the write port in the current cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WB   = 2'd1,
    GNT_LD   = 2'd2
  } gnt_src_t;

endpackage

// File: rtl/rf_ld_fifo.sv
// Load-return buffer: synchronous FIFO with registered occupancy and a
// combinational head. A push into a full FIFO is taken only when a pop frees a slot.
module rf_ld_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37
) (
  input  logic         clk,
  input  logic         RST,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] head_data,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    // Pointers wrap naturally because DEPTH is a power of two.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: shares WE3/A3/WD3 between pipeline
// writeback and buffered late load returns, plus the pending-load scoreboard.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_WIDTH   = REG_DATA_W,
  parameter int ADDR_WIDTH   = REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_hold,
  input  logic                  ld_issue,
  input  logic [ADDR_WIDTH-1:0] ld_issue_addr,
  output logic                  ld_issue_stall,
  input  logic                  ld_ret_valid,
  input  logic [ADDR_WIDTH-1:0] ld_ret_addr,
  input  logic [DATA_WIDTH-1:0] ld_ret_data,
  output logic                  ld_ret_ready,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  hazard_stall,
  output logic                  WE3,
  output logic [ADDR_WIDTH-1:0] A3,
  output logic [DATA_WIDTH-1:0] WD3
);

  localparam int NREG = 1 << ADDR_WIDTH;
  localparam int SW   = $clog2(STARVE_LIMIT + 1);
  localparam int FW   = ADDR_WIDTH + DATA_WIDTH;

  logic                  fifo_push, fifo_full, fifo_empty;
  logic [FW-1:0]         fifo_head;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;

  logic [SW-1:0]         starve_cnt_q, starve_cnt_d;
  logic [NREG-1:0]       pending_q, pending_d;

  gnt_src_t              gnt;
  logic                  load_pri, drain, ret_ready;
  logic                  issue_stall, issue_accept, hazard;
  logic                  hold_w, we3_w;
  logic [ADDR_WIDTH-1:0] a3_w;
  logic [DATA_WIDTH-1:0] wd3_w;

  // Returns to x0 are acknowledged but never stored.
  assign ret_ready = !fifo_full;
  assign fifo_push = ld_ret_valid && ret_ready && (ld_ret_addr != '0);

  rf_ld_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (FW)
  ) u_ld_fifo (
    .clk       (clk),
    .RST       (RST),
    .push      (fifo_push),
    .pop       (drain),
    .push_data ({ld_ret_addr, ld_ret_data}),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_addr = fifo_head[FW-1:DATA_WIDTH];
  assign head_data = fifo_head[DATA_WIDTH-1:0];

  // Grant: a starved FIFO beats writeback, otherwise writeback beats the FIFO.
  always_comb begin
    load_pri = !fifo_empty && (starve_cnt_q == SW'(STARVE_LIMIT));
    gnt      = GNT_NONE;
    hold_w   = 1'b0;
    if (load_pri) begin
      gnt    = GNT_LD;
      hold_w = wb_valid;
    end else if (wb_valid) begin
      gnt = GNT_WB;
    end else if (!fifo_empty) begin
      gnt = GNT_LD;
    end
    drain = (gnt == GNT_LD);
  end

  always_comb begin
    a3_w  = '0;
    wd3_w = '0;
    case (gnt)
      GNT_WB: begin
        a3_w  = wb_addr;
        wd3_w = wb_data;
      end
      GNT_LD: begin
        a3_w  = head_addr;
        wd3_w = head_data;
      end
      default: begin
        a3_w  = '0;
        wd3_w = '0;
      end
    endcase
    we3_w = (gnt != GNT_NONE) && (a3_w != '0);
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (drain || fifo_empty) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != SW'(STARVE_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + SW'(1);
    end
  end

  // A re-issue to the register being drained this cycle is allowed through.
  always_comb begin
    issue_stall  = ld_issue && (ld_issue_addr != '0) && pending_q[ld_issue_addr] &&
                   !(drain && (head_addr == ld_issue_addr));
    issue_accept = ld_issue && !issue_stall && (ld_issue_addr != '0);
    pending_d    = pending_q;
    if (drain) begin
      pending_d[head_addr] = 1'b0;
    end
    if (issue_accept) begin
      pending_d[ld_issue_addr] = 1'b1;
    end
    pending_d[0] = 1'b0;
    hazard = pending_q[rs1_addr] || pending_q[rs2_addr] || pending_q[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      starve_cnt_q <= '0;
      pending_q    <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      pending_q    <= pending_d;
    end
  end

  // Every output is held at zero for as long as reset is asserted.
  always_comb begin
    wb_hold        = RST && hold_w;
    ld_issue_stall = RST && issue_stall;
    ld_ret_ready   = RST && ret_ready;
    hazard_stall   = RST && hazard;
    WE3            = RST && we3_w;
    A3             = RST ? a3_w : '0;
    WD3            = RST ? wd3_w : '0;
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: register-file writes are checked by a
// cycle-stamped scoreboard monitor, control outputs by inline checks.
module tb_rf_wb_arbiter;

  localparam int EW = 32 + 5 + 32;

  logic        clk = 1'b0;
  logic        RST = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        wb_hold;
  logic        ld_issue = 1'b0;
  logic [4:0]  ld_issue_addr = '0;
  logic        ld_issue_stall;
  logic        ld_ret_valid = 1'b0;
  logic [4:0]  ld_ret_addr = '0;
  logic [31:0] ld_ret_data = '0;
  logic        ld_ret_ready;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic [4:0]  rd_addr = '0;
  logic        hazard_stall;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;

  logic [31:0]   cyc = '0;
  logic [EW-1:0] exp_q[$];
  int            n_cmp = 0;
  int            n_err = 0;

  rf_wb_arbiter #(
    .FIFO_DEPTH   (2),
    .STARVE_LIMIT (4),
    .DATA_WIDTH   (32),
    .ADDR_WIDTH   (5)
  ) dut (
    .clk            (clk),
    .RST            (RST),
    .wb_valid       (wb_valid),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .wb_hold        (wb_hold),
    .ld_issue       (ld_issue),
    .ld_issue_addr  (ld_issue_addr),
    .ld_issue_stall (ld_issue_stall),
    .ld_ret_valid   (ld_ret_valid),
    .ld_ret_addr    (ld_ret_addr),
    .ld_ret_data    (ld_ret_data),
    .ld_ret_ready   (ld_ret_ready),
    .rs1_addr       (rs1_addr),
    .rs2_addr       (rs2_addr),
    .rd_addr        (rd_addr),
    .hazard_stall   (hazard_stall),
    .WE3            (WE3),
    .A3             (A3),
    .WD3            (WD3)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic expect_wr(input int lat, input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({cyc + 32'(lat), a, d});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle_inputs();
    wb_valid      = 1'b0;
    ld_issue      = 1'b0;
    ld_ret_valid  = 1'b0;
    rs1_addr      = '0;
    rs2_addr      = '0;
    rd_addr       = '0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    while (exp_q.size() > 0 && exp_q[0][EW-1:37] < cyc) begin
      e = exp_q.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL wr_missing: got no write, expected cyc %0d A3=%0d WD3=%0h",
               e[EW-1:37], e[36:32], e[31:0]);
    end
    if (WE3) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL wr_unexpected: got cyc %0d A3=%0d WD3=%0h, expected no write",
                 cyc, A3, WD3);
      end else begin
        e = exp_q.pop_front();
        if (e !== {cyc, A3, WD3}) begin
          n_err++;
          $display("FAIL wr_data: got cyc %0d A3=%0d WD3=%0h, expected cyc %0d A3=%0d WD3=%0h",
                   cyc, A3, WD3, e[EW-1:37], e[36:32], e[31:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset: outputs forced low while RST is low.
    tick();
    at_neg();
    chk("rst_ready_low", 32'(ld_ret_ready), 32'd0);
    chk("rst_we3_low", 32'(WE3), 32'd0);
    tick();
    RST = 1'b1;
    at_neg();
    chk("rst_ready_after", 32'(ld_ret_ready), 32'd1);
    chk("rst_hazard_after", 32'(hazard_stall), 32'd0);
    chk("rst_we3_after", 32'(WE3), 32'd0);

    // Writeback alone: same-cycle write.
    tick();
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    expect_wr(0, 5'd5, 32'hDEADBEEF);
    at_neg();
    chk("wb_alone_hold", 32'(wb_hold), 32'd0);
    chk("wb_alone_we3", 32'(WE3), 32'd1);
    tick();
    idle_inputs();

    // Load round trip to x7.
    tick();
    ld_issue = 1'b1; ld_issue_addr = 5'd7; rs1_addr = 5'd7;
    at_neg();
    chk("rt_issue_stall", 32'(ld_issue_stall), 32'd0);
    chk("rt_hazard_issue", 32'(hazard_stall), 32'd0);
    tick();
    ld_issue = 1'b0;
    ld_ret_valid = 1'b1; ld_ret_addr = 5'd7; ld_ret_data = 32'h1234;
    expect_wr(1, 5'd7, 32'h1234);
    at_neg();
    chk("rt_hazard_pending", 32'(hazard_stall), 32'd1);
    chk("rt_ret_ready", 32'(ld_ret_ready), 32'd1);
    tick();
    ld_ret_valid = 1'b0;
    at_neg();
    chk("rt_hazard_drain", 32'(hazard_stall), 32'd1);
    tick();
    at_neg();
    chk("rt_hazard_release", 32'(hazard_stall), 32'd0);
    tick();
    idle_inputs();

    // Starvation: return to x3 under continuous writeback to x10.
    for (int i = 0; i < 7; i++) begin
      tick();
      wb_valid     = 1'b1;
      wb_addr      = 5'd10;
      wb_data      = 32'hA0 + 32'((i < 5) ? i : 5);
      ld_ret_valid = (i == 0);
      ld_ret_addr  = 5'd3;
      ld_ret_data  = 32'h33;
      if (i == 5) expect_wr(0, 5'd3, 32'h33);
      else        expect_wr(0, 5'd10, wb_data);
      at_neg();
      chk("starve_wb_hold", 32'(wb_hold), 32'(i == 5));
    end
    tick();
    idle_inputs();

    // FIFO full: x1, x2 accepted, x4 waits for the first drain.
    for (int i = 0; i < 9; i++) begin
      tick();
      wb_valid     = (i <= 6);
      wb_addr      = 5'd11;
      wb_data      = 32'hB0 + 32'((i < 5) ? i : 5);
      ld_ret_valid = (i <= 6);
      ld_ret_addr  = (i == 0) ? 5'd1 : (i == 1) ? 5'd2 : 5'd4;
      ld_ret_data  = (i == 0) ? 32'h11 : (i == 1) ? 32'h22 : 32'h44;
      if (i <= 4 || i == 6) expect_wr(0, 5'd11, wb_data);
      else if (i == 5)      expect_wr(0, 5'd1, 32'h11);
      else if (i == 7)      expect_wr(0, 5'd2, 32'h22);
      else                  expect_wr(0, 5'd4, 32'h44);
      at_neg();
      if (i <= 6) chk("full_ret_ready", 32'(ld_ret_ready), 32'((i <= 1) || (i == 6)));
      chk("full_wb_hold", 32'(wb_hold), 32'(i == 5));
    end
    tick();
    idle_inputs();

    // Duplicate issue to x9, and re-issue in the drain cycle.
    tick();
    ld_issue = 1'b1; ld_issue_addr = 5'd9; rd_addr = 5'd9;
    at_neg();
    chk("dup_first_stall", 32'(ld_issue_stall), 32'd0);
    tick();
    ld_ret_valid = 1'b1; ld_ret_addr = 5'd9; ld_ret_data = 32'h99;
    expect_wr(1, 5'd9, 32'h99);
    at_neg();
    chk("dup_second_stall", 32'(ld_issue_stall), 32'd1);
    chk("dup_hazard_rd", 32'(hazard_stall), 32'd1);
    tick();
    ld_ret_valid = 1'b0;
    at_neg();
    chk("dup_drain_issue_stall", 32'(ld_issue_stall), 32'd0);
    tick();
    ld_ret_valid = 1'b1; ld_ret_addr = 5'd9; ld_ret_data = 32'h98;
    expect_wr(1, 5'd9, 32'h98);
    at_neg();
    chk("dup_still_pending_hazard", 32'(hazard_stall), 32'd1);
    chk("dup_still_pending_stall", 32'(ld_issue_stall), 32'd1);
    tick();
    ld_issue = 1'b0; ld_ret_valid = 1'b0;
    at_neg();
    chk("dup_hazard_drain2", 32'(hazard_stall), 32'd1);
    tick();
    at_neg();
    chk("dup_hazard_clear", 32'(hazard_stall), 32'd0);
    tick();
    idle_inputs();

    // x0: issue, writeback and return to x0 never write.
    tick();
    ld_issue = 1'b1; ld_issue_addr = 5'd0;
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'h55;
    ld_ret_valid = 1'b1; ld_ret_addr = 5'd0; ld_ret_data = 32'hFFFF;
    at_neg();
    chk("x0_issue_stall", 32'(ld_issue_stall), 32'd0);
    chk("x0_wb_we3", 32'(WE3), 32'd0);
    chk("x0_ret_ready", 32'(ld_ret_ready), 32'd1);
    chk("x0_wb_hold", 32'(wb_hold), 32'd0);
    tick();
    idle_inputs();
    at_neg();
    chk("x0_ret_not_enqueued", 32'(WE3), 32'd0);

    // Reset mid-operation: pending x6/x7, two buffered returns.
    tick();
    ld_issue = 1'b1; ld_issue_addr = 5'd6; rs1_addr = 5'd6; rs2_addr = 5'd7;
    tick();
    ld_issue_addr = 5'd7;
    tick();
    ld_issue = 1'b0;
    wb_valid = 1'b1; wb_addr = 5'd12; wb_data = 32'hC0;
    ld_ret_valid = 1'b1; ld_ret_addr = 5'd6; ld_ret_data = 32'h66;
    expect_wr(0, 5'd12, 32'hC0);
    at_neg();
    chk("mid_hazard_pre", 32'(hazard_stall), 32'd1);
    tick();
    wb_data = 32'hC1;
    ld_ret_addr = 5'd7; ld_ret_data = 32'h77;
    expect_wr(0, 5'd12, 32'hC1);
    at_neg();
    chk("mid_ready_one_entry", 32'(ld_ret_ready), 32'd1);
    tick();
    RST = 1'b0;
    ld_ret_valid = 1'b0;
    wb_data = 32'hC2;
    at_neg();
    chk("mid_rst_we3", 32'(WE3), 32'd0);
    chk("mid_rst_a3", 32'(A3), 32'd0);
    chk("mid_rst_wd3", WD3, 32'd0);
    chk("mid_rst_hold", 32'(wb_hold), 32'd0);
    chk("mid_rst_ready", 32'(ld_ret_ready), 32'd0);
    chk("mid_rst_hazard", 32'(hazard_stall), 32'd0);
    tick();
    RST = 1'b1;
    wb_valid = 1'b0;
    ld_issue = 1'b1; ld_issue_addr = 5'd6;
    at_neg();
    chk("mid_post_ready", 32'(ld_ret_ready), 32'd1);
    chk("mid_post_hazard", 32'(hazard_stall), 32'd0);
    chk("mid_post_issue_stall", 32'(ld_issue_stall), 32'd0);
    chk("mid_post_we3", 32'(WE3), 32'd0);
    tick();
    idle_inputs();
    at_neg();
    chk("mid_post_flushed_we3", 32'(WE3), 32'd0);

    // Let outstanding expectations retire, bounded.
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) tick();
    tick();
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL sb_drain: got %0d writes outstanding, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
